// File: rtl/ram_loop_test.sv
// ram_loop_test: write-then-verify controller for a simple dual-port block RAM.
// Writes a selectable pattern to every address on port A, reads it back on
// port B, compares each word against the regenerated pattern and reports
// pass/fail, the mismatch count and the first failing address.
//
// Ports:
//   sys_clk, sys_rst_n        clock, asynchronous active-low reset
//   start, mode, seed, err_inj run request and run configuration (sampled in IDLE)
//   ram_wr_en/we/addr/data    RAM port A (write)
//   ram_rd_en/addr, ram_rd_data RAM port B (read)
//   rd_flag, busy, done       phase/status flags
//   pass, err_cnt, first_err_addr  result of the last run
module ram_loop_test #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic              err_inj,
  output logic              ram_wr_en,
  output logic              ram_wr_we,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              rd_flag,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned XW    = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
  localparam int unsigned DRN_W = 2;
  localparam logic [DRN_W-1:0]  DRAIN_LAST = DRN_W'(RD_LAT);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_GAP, S_READ, S_DRAIN, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic [DATA_W-1:0]   walk_q, walk_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]   rd_exp_q, rd_exp_d;
  logic                rd_flag_q, rd_flag_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]   first_q, first_d;
  logic [DRN_W-1:0]    drain_q, drain_d;
  logic [RD_LAT-1:0]             dl_vld_q, dl_vld_d;
  logic [RD_LAT-1:0][DATA_W-1:0] dl_exp_q, dl_exp_d;
  logic [RD_LAT-1:0][ADDR_W-1:0] dl_addr_q, dl_addr_d;

  logic [ADDR_W-1:0] wr_nxt_addr, rd_nxt_addr;
  logic [DATA_W-1:0] walk_nxt;

  // Address zero-extended or truncated to the data width.
  function automatic logic [DATA_W-1:0] addr_ext(input logic [ADDR_W-1:0] a);
    logic [XW-1:0] w;
    w = XW'(a);
    return w[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] v);
    return {v[DATA_W-2:0], v[DATA_W-1]};
  endfunction

  // Pattern word for one address; mode 3 falls back to seed+addr.
  function automatic logic [DATA_W-1:0] pat(input logic [1:0]        m,
                                            input logic [DATA_W-1:0] s,
                                            input logic [ADDR_W-1:0] a,
                                            input logic [DATA_W-1:0] w);
    case (m)
      2'd1:    return ~addr_ext(a) ^ s;
      2'd2:    return w;
      default: return s + addr_ext(a);
    endcase
  endfunction

  assign wr_nxt_addr = wr_addr_q + ADDR_W'(1);
  assign rd_nxt_addr = rd_addr_q + ADDR_W'(1);
  assign walk_nxt    = rotl(walk_q);

  // Next-state, delay line, compare and output logic.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    seed_d    = seed_q;
    walk_d    = walk_q;
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    rd_en_d   = 1'b0;
    rd_addr_d = '0;
    rd_exp_d  = '0;
    rd_flag_d = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    err_cnt_d = err_cnt_q;
    first_d   = first_q;
    drain_d   = drain_q;

    // Expected word/address follow the read through an RD_LAT-deep line (RD_LAT is 1 or 2).
    dl_vld_d     = dl_vld_q;
    dl_exp_d     = dl_exp_q;
    dl_addr_d    = dl_addr_q;
    dl_vld_d[0]  = rd_en_q;
    dl_exp_d[0]  = rd_exp_q;
    dl_addr_d[0] = rd_addr_q;
    if (RD_LAT > 1) begin
      dl_vld_d[RD_LAT-1]  = dl_vld_q[0];
      dl_exp_d[RD_LAT-1]  = dl_exp_q[0];
      dl_addr_d[RD_LAT-1] = dl_addr_q[0];
    end

    // Compare the read data that is valid this cycle.
    if (dl_vld_q[RD_LAT-1] && (ram_rd_data != dl_exp_q[RD_LAT-1])) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
      if (err_cnt_q == '0) begin
        first_d = dl_addr_q[RD_LAT-1];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d    = mode;
          seed_d    = seed;
          err_cnt_d = '0;
          first_d   = '0;
          pass_d    = 1'b0;
          busy_d    = 1'b1;
          walk_d    = DATA_W'(1);
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          // err_inj only ever affects address 0, which is written right now.
          wr_data_d = pat(mode, seed, '0, DATA_W'(1)) ^ DATA_W'(err_inj);
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        if (wr_addr_q == ADDR_LAST) begin
          rd_flag_d = 1'b1;
          state_d   = S_GAP;
        end else begin
          walk_d    = walk_nxt;
          wr_en_d   = 1'b1;
          wr_addr_d = wr_nxt_addr;
          wr_data_d = pat(mode_q, seed_q, wr_nxt_addr, walk_nxt);
        end
      end
      S_GAP: begin
        walk_d    = DATA_W'(1);
        rd_en_d   = 1'b1;
        rd_addr_d = '0;
        rd_exp_d  = pat(mode_q, seed_q, '0, DATA_W'(1));
        state_d   = S_READ;
      end
      S_READ: begin
        if (rd_addr_q == ADDR_LAST) begin
          drain_d = '0;
          state_d = S_DRAIN;
        end else begin
          walk_d    = walk_nxt;
          rd_en_d   = 1'b1;
          rd_addr_d = rd_nxt_addr;
          rd_exp_d  = pat(mode_q, seed_q, rd_nxt_addr, walk_nxt);
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == '0);
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + DRN_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      seed_q    <= '0;
      walk_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_exp_q  <= '0;
      rd_flag_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_cnt_q <= '0;
      first_q   <= '0;
      drain_q   <= '0;
      dl_vld_q  <= '0;
      dl_exp_q  <= '0;
      dl_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      seed_q    <= seed_d;
      walk_q    <= walk_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      rd_exp_q  <= rd_exp_d;
      rd_flag_q <= rd_flag_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_cnt_q <= err_cnt_d;
      first_q   <= first_d;
      drain_q   <= drain_d;
      dl_vld_q  <= dl_vld_d;
      dl_exp_q  <= dl_exp_d;
      dl_addr_q <= dl_addr_d;
    end
  end

  assign ram_wr_en      = wr_en_q;
  assign ram_wr_we      = wr_en_q;
  assign ram_wr_addr    = wr_addr_q;
  assign ram_wr_data    = wr_data_q;
  assign ram_rd_en      = rd_en_q;
  assign ram_rd_addr    = rd_addr_q;
  assign rd_flag        = rd_flag_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_q;

endmodule
